// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard detection and operand forwarding for the 8-bit execute stage.
// Tracks destination registers of the EX/MEM/WB instructions, registers
// the ALU A/B forwarding selects for the instruction entering EX, raises a
// combinational load-use stall and marks bubbles entering EX.
module hazard_forward_unit #(
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_b_const,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            aluInputAForwardingSel,
  output logic [1:0]            aluInputBForwardingSel,
  output logic                  stall,
  output logic                  ex_bubble
);

  // Forwarding-mux select encoding seen by the ALU input muxes.
  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } fwd_sel_e;

  // Per-stage tracking state.
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_wr;
  logic                  r_ex_ld;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_mem_ld;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_wr;

  // Registered outputs.
  fwd_sel_e              r_sel_a;
  fwd_sel_e              r_sel_b;
  logic                  r_ex_bubble;

  // Operand usage and hit detection.
  logic                  w_use_a;
  logic                  w_use_b;
  logic                  w_hit_ex_a;
  logic                  w_hit_ex_b;
  logic                  w_hit_mem_a;
  logic                  w_hit_mem_b;
  logic                  w_ldu_a;
  logic                  w_ldu_b;
  logic                  w_stall;
  logic                  w_bubble;
  fwd_sel_e              w_sel_a;
  fwd_sel_e              w_sel_b;

  // Pick the youngest non-load producer; load producers never reach here
  // because they force a stall, which turns the slot into a bubble.
  function automatic fwd_sel_e pick_sel(input logic used,
                                        input logic hit_ex,
                                        input logic hit_mem);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (used) begin
      if (hit_ex) begin
        sel = FWD_EX_MEM;
      end else if (hit_mem) begin
        sel = FWD_MEM_WB;
      end
    end
    return sel;
  endfunction

  // Operand qualification and register-match detection against EX and MEM.
  always_comb begin
    w_use_a     = id_uses_rs1;
    w_use_b     = id_uses_rs2 & ~id_b_const;
    w_hit_ex_a  = r_ex_wr  & (r_ex_rd  == id_rs1);
    w_hit_ex_b  = r_ex_wr  & (r_ex_rd  == id_rs2);
    w_hit_mem_a = r_mem_wr & (r_mem_rd == id_rs1);
    w_hit_mem_b = r_mem_wr & (r_mem_rd == id_rs2);
  end

  // Load-use stall, bubble decision and next-cycle selects.
  always_comb begin
    // A younger non-load match in EX shadows an older load in MEM.
    w_ldu_a  = w_use_a & ((w_hit_ex_a & r_ex_ld) |
                          (w_hit_mem_a & r_mem_ld & ~w_hit_ex_a));
    w_ldu_b  = w_use_b & ((w_hit_ex_b & r_ex_ld) |
                          (w_hit_mem_b & r_mem_ld & ~w_hit_ex_b));
    w_stall  = id_valid & ~flush & (w_ldu_a | w_ldu_b);
    w_bubble = w_stall | flush | ~id_valid;
    w_sel_a  = FWD_REG;
    w_sel_b  = FWD_REG;
    if (!w_bubble) begin
      w_sel_a = pick_sel(w_use_a, w_hit_ex_a, w_hit_mem_a);
      w_sel_b = pick_sel(w_use_b, w_hit_ex_b, w_hit_mem_b);
    end
  end

  // Pipeline tracking: ID -> EX -> MEM -> WB, bubbles clear write/load flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_rd  <= '0;
      r_ex_wr  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_wr <= 1'b0;
      r_mem_ld <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_wr  <= 1'b0;
    end else begin
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      r_mem_rd <= r_ex_rd;
      r_mem_wr <= r_ex_wr;
      r_mem_ld <= r_ex_ld;
      r_ex_rd  <= id_rd;
      if (w_bubble) begin
        r_ex_wr <= 1'b0;
        r_ex_ld <= 1'b0;
      end else begin
        r_ex_wr <= id_reg_write;
        r_ex_ld <= id_mem_read;
      end
    end
  end

  // Register the forwarding selects and bubble flag as the instruction enters EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_a     <= FWD_REG;
      r_sel_b     <= FWD_REG;
      r_ex_bubble <= 1'b1;
    end else begin
      r_sel_a     <= w_sel_a;
      r_sel_b     <= w_sel_b;
      r_ex_bubble <= w_bubble;
    end
  end

  // WB tracking must always hold a defined register address when it is writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown({r_wb_wr, r_wb_rd}));
    end
  end

  assign aluInputAForwardingSel = r_sel_a;
  assign aluInputBForwardingSel = r_sel_b;
  assign stall                  = w_stall;
  assign ex_bubble              = r_ex_bubble;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard testbench for hazard_forward_unit: the driver applies one
// directed ID vector per cycle and queues its hand-computed expectations;
// the monitor pops one entry per cycle and compares outputs.
module tb_hazard_forward_unit;

  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic          id_b_const;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          stall;
  logic          ex_bubble;

  hazard_forward_unit #(.REG_ADDR_W(AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .id_valid               (id_valid),
    .id_rs1                 (id_rs1),
    .id_rs2                 (id_rs2),
    .id_uses_rs1            (id_uses_rs1),
    .id_uses_rs2            (id_uses_rs2),
    .id_b_const             (id_b_const),
    .id_rd                  (id_rd),
    .id_reg_write           (id_reg_write),
    .id_mem_read            (id_mem_read),
    .flush                  (flush),
    .aluInputAForwardingSel (sel_a),
    .aluInputBForwardingSel (sel_b),
    .stall                  (stall),
    .ex_bubble              (ex_bubble)
  );

  typedef struct {
    int         idx;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
    logic       bub;
  } exp_t;

  exp_t q[$];
  exp_t mon_prev;
  int   n_checks = 0;
  int   n_err    = 0;
  int   row_idx  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic bc,
                        input logic [AW-1:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_b_const = bc; id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  // One ID cycle: expected stall this cycle, and selects/bubble seen next cycle.
  task automatic row(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic u1, input logic u2, input logic bc,
                     input logic [AW-1:0] rd, input logic rw, input logic mr, input logic fl,
                     input logic est, input logic [1:0] ea, input logic [1:0] eb, input logic ebub);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(v, rs1, rs2, u1, u2, bc, rd, rw, mr, fl);
    row_idx++;
    e.idx = row_idx; e.st = est; e.a = ea; e.b = eb; e.bub = ebub;
    q.push_back(e);
  endtask

  task automatic nop();
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'd0, 2'd0, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"}, {1'b0, stall},     2'd0);
    chk({tag, "_asel"},  sel_a,             2'd0);
    chk({tag, "_bsel"},  sel_b,             2'd0);
    chk({tag, "_bub"},   {1'b0, ex_bubble}, 2'd1);
  endtask

  // Monitor: registered outputs now belong to the previous row, stall to this one.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk($sformatf("r%0d_asel", mon_prev.idx), sel_a, mon_prev.a);
        chk($sformatf("r%0d_bsel", mon_prev.idx), sel_b, mon_prev.b);
        chk($sformatf("r%0d_bub",  mon_prev.idx), {1'b0, ex_bubble}, {1'b0, mon_prev.bub});
        chk($sformatf("r%0d_stall", cur.idx),     {1'b0, stall},     {1'b0, cur.st});
        mon_prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    mon_prev.idx = 0; mon_prev.st = 1'b0; mon_prev.a = 2'd0; mon_prev.b = 2'd0; mon_prev.bub = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset_state("por");
    repeat (2) @(posedge clk);
    #1 chk_reset_state("por_held");
    @(negedge clk) rst = 1'b1;

    // Back-to-back ALU: r3 forwarded from EX/MEM on A.
    row(1, 0, 0, 0, 0, 0, 3, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    row(1, 3, 1, 1, 1, 0, 7, 1, 0, 0,  0, 2'd1, 2'd0, 0);
    nop(); nop(); nop();
    // Distance 2 on B, then same with constant B.
    row(1, 0, 0, 0, 0, 0, 5, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    nop();
    row(1, 0, 5, 1, 1, 0, 1, 0, 0, 0,  0, 2'd0, 2'd2, 0);
    row(1, 0, 0, 0, 0, 0, 5, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    nop();
    row(1, 0, 5, 0, 1, 1, 1, 0, 0, 0,  0, 2'd0, 2'd0, 0);
    // Double producer of r2: youngest wins.
    row(1, 0, 0, 0, 0, 0, 2, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    row(1, 0, 0, 0, 0, 0, 2, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    row(1, 2, 0, 1, 0, 0, 0, 0, 0, 0,  0, 2'd1, 2'd0, 0);
    nop(); nop();
    // Load-use at distance 1: two stall cycles.
    row(1, 1, 0, 1, 0, 0, 4, 1, 1, 0,  0, 2'd0, 2'd0, 0);
    row(1, 4, 0, 1, 0, 0, 6, 1, 0, 0,  1, 2'd0, 2'd0, 1);
    row(1, 4, 0, 1, 0, 0, 6, 1, 0, 0,  1, 2'd0, 2'd0, 1);
    row(1, 4, 0, 1, 0, 0, 6, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    nop(); nop();
    // Flush in first stall cycle, then load at distance 2 on B: one stall.
    row(1, 0, 0, 0, 0, 0, 4, 1, 1, 0,  0, 2'd0, 2'd0, 0);
    row(1, 4, 0, 1, 0, 0, 6, 1, 0, 1,  0, 2'd0, 2'd0, 1);
    row(1, 0, 4, 0, 1, 0, 0, 1, 0, 0,  1, 2'd0, 2'd0, 1);
    row(1, 0, 4, 0, 1, 0, 0, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    // Register 0 is tracked like any other.
    row(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 2'd1, 2'd0, 0);
    nop(); nop();
    // Load r3, then reset asserted while the consumer is stalling.
    row(1, 0, 0, 0, 0, 0, 3, 1, 1, 0,  0, 2'd0, 2'd0, 0);
    @(posedge clk);
    #1 set_in(1, 3, 0, 1, 0, 0, 6, 1, 0, 0);
    #1 chk("pre_reset_stall", {1'b0, stall}, 2'd1);
    rst = 1'b0;
    mon_prev.idx = 0; mon_prev.st = 1'b0; mon_prev.a = 2'd0; mon_prev.b = 2'd0; mon_prev.bub = 1'b1;
    #1 chk_reset_state("mid_rst");
    @(posedge clk);
    #1 chk_reset_state("mid_rst_held");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    // After release the old load is gone; the first dependency forwards.
    row(1, 3, 0, 1, 0, 0, 6, 1, 0, 0,  0, 2'd0, 2'd0, 0);
    row(1, 0, 6, 0, 1, 0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 0);
    nop(); nop();

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
